// File: rtl/pulse_to_level_gen.sv
// pulse_to_level_gen
// Converts single-cycle request strobes into level pulses of programmable
// width, separated by a programmable low gap. Strobes that arrive while a
// pulse or gap is running are held as a count and replayed in order.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no pulse running, queue empty, waiting for pulse_in
//  HIGH  | data_out high; timer counts down the latched width
//  GAP   | data_out low; timer counts down the latched gap, then
//        | either starts the next queued pulse or returns to IDLE
module pulse_to_level_gen #(
   parameter int W_BITS   = 8,
   parameter int G_BITS   = 8,
   parameter int MAX_PEND = 15,
   parameter int P_BITS   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pulse_in,
   input  logic [W_BITS-1:0] width_cfg,
   input  logic [G_BITS-1:0] gap_cfg,
   input  logic              clr_ovf,
   output logic              data_out,
   output logic              busy,
   output logic [P_BITS-1:0] pend_cnt,
   output logic              overflow
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // The phase timer is shared by HIGH and GAP, so it must hold either.
   localparam int C_BITS = (W_BITS > G_BITS) ? W_BITS : G_BITS;
   localparam logic [P_BITS-1:0] PEND_FULL = P_BITS'(MAX_PEND);

   state_t            state_q;
   state_t            state_d;
   logic [C_BITS-1:0] tmr_q;
   logic [C_BITS-1:0] tmr_d;
   logic [P_BITS-1:0] pend_d;
   logic              ovf_d;
   logic              data_d;
   logic              busy_d;

   logic              enq;
   logic              deq;
   logic              drop;
   logic              tmr_tc;

   logic [W_BITS-1:0] width_m1;
   logic [G_BITS-1:0] gap_m1;
   logic [C_BITS-1:0] eff_w_load;
   logic [C_BITS-1:0] eff_g_load;

   // Timer load values are length-1 so terminal count (zero) marks the
   // last cycle of a phase; a zero config is treated as a length of one.
   assign width_m1   = width_cfg - W_BITS'(1);
   assign gap_m1     = gap_cfg - G_BITS'(1);
   assign eff_w_load = (width_cfg == '0) ? '0 : C_BITS'(width_m1);
   assign eff_g_load = (gap_cfg == '0) ? '0 : C_BITS'(gap_m1);
   assign tmr_tc     = (tmr_q == '0);

   // Next-state, timer, queue and overflow decisions.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      pend_d  = pend_cnt;
      ovf_d   = overflow;
      enq     = 1'b0;
      deq     = 1'b0;
      drop    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The starting strobe is consumed directly, never queued.
            if (pulse_in) begin
               state_d = ST_HIGH;
               tmr_d   = eff_w_load;
            end
         end

         ST_HIGH: begin
            enq = pulse_in;
            if (tmr_tc) begin
               state_d = ST_GAP;
               tmr_d   = eff_g_load;
            end else begin
               tmr_d = tmr_q - C_BITS'(1);
            end
         end

         ST_GAP: begin
            if (tmr_tc) begin
               if (pend_cnt != '0) begin
                  // Replay the oldest queued request; a strobe arriving now
                  // takes the freed slot, so it can never overflow.
                  deq     = 1'b1;
                  enq     = pulse_in;
                  state_d = ST_HIGH;
                  tmr_d   = eff_w_load;
               end else if (pulse_in) begin
                  state_d = ST_HIGH;
                  tmr_d   = eff_w_load;
               end else begin
                  state_d = ST_IDLE;
                  tmr_d   = '0;
               end
            end else begin
               enq   = pulse_in;
               tmr_d = tmr_q - C_BITS'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
         end
      endcase

      if (deq && !enq) begin
         pend_d = pend_cnt - P_BITS'(1);
      end else if (enq && !deq) begin
         if (pend_cnt < PEND_FULL) begin
            pend_d = pend_cnt + P_BITS'(1);
         end else begin
            drop = 1'b1;
         end
      end

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end

      data_d = (state_d == ST_HIGH);
      busy_d = (state_d != ST_IDLE);
   end

   // State, timer, queue count and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         tmr_q    <= '0;
         pend_cnt <= '0;
         overflow <= 1'b0;
         data_out <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         pend_cnt <= pend_d;
         overflow <= ovf_d;
         data_out <= data_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_pulse_to_level_gen.sv
// Directed bench for pulse_to_level_gen. Cycle n of a scenario is the
// interval after the n-th rising edge following reset release; inputs are
// driven and outputs sampled 1 time unit after each rising edge.
module tb_pulse_to_level_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       pulse_in;
   logic [7:0] width_cfg;
   logic [7:0] gap_cfg;
   logic       clr_ovf;
   logic       data_out;
   logic       busy;
   logic [3:0] pend_cnt;
   logic       overflow;

   int n_cmp = 0;
   int n_err = 0;

   pulse_to_level_gen #(
      .W_BITS  (8),
      .G_BITS  (8),
      .MAX_PEND(15),
      .P_BITS  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .pulse_in (pulse_in),
      .width_cfg(width_cfg),
      .gap_cfg  (gap_cfg),
      .clr_ovf  (clr_ovf),
      .data_out (data_out),
      .busy     (busy),
      .pend_cnt (pend_cnt),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst      = 1'b1;
      pulse_in = 1'b0;
      clr_ovf  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      pulse_in  = 1'b1;
      clr_ovf   = 1'b0;
      width_cfg = 8'd3;
      gap_cfg   = 8'd2;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (data_out !== 1'b0) begin n_err++; $display("FAIL reset_data_out got=%b want=0", data_out); end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
      n_cmp++;
      if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL reset_pend got=%0d want=0", pend_cnt); end
      n_cmp++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", overflow); end
      rst      = 1'b0;
      pulse_in = 1'b0;
   endtask

   task automatic test_single();
      logic e_d, e_b;
      do_reset();
      width_cfg = 8'd3;
      gap_cfg   = 8'd2;
      for (int c = 0; c <= 20; c++) begin
         pulse_in = (c == 10);
         e_d = (c >= 11 && c <= 13);
         e_b = (c >= 11 && c <= 15);
         n_cmp++;
         if (data_out !== e_d) begin n_err++; $display("FAIL single_data c=%0d got=%b want=%b", c, data_out, e_d); end
         n_cmp++;
         if (busy !== e_b) begin n_err++; $display("FAIL single_busy c=%0d got=%b want=%b", c, busy, e_b); end
         n_cmp++;
         if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL single_pend c=%0d got=%0d want=0", c, pend_cnt); end
         @(posedge clk); #1;
      end
      pulse_in = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic e_d, e_b;
      logic [3:0] e_p;
      do_reset();
      width_cfg = 8'd2;
      gap_cfg   = 8'd1;
      for (int c = 0; c <= 22; c++) begin
         pulse_in = (c == 10 || c == 12 || c == 13);
         e_d = (c == 11 || c == 12 || c == 14 || c == 15 || c == 17 || c == 18);
         e_b = (c >= 11 && c <= 19);
         e_p = (c >= 13 && c <= 16) ? 4'd1 : 4'd0;
         n_cmp++;
         if (data_out !== e_d) begin n_err++; $display("FAIL b2b_data c=%0d got=%b want=%b", c, data_out, e_d); end
         n_cmp++;
         if (busy !== e_b) begin n_err++; $display("FAIL b2b_busy c=%0d got=%b want=%b", c, busy, e_b); end
         n_cmp++;
         if (pend_cnt !== e_p) begin n_err++; $display("FAIL b2b_pend c=%0d got=%0d want=%0d", c, pend_cnt, e_p); end
         @(posedge clk); #1;
      end
      pulse_in = 1'b0;
   endtask

   task automatic test_zero_cfg();
      logic e_d, e_b;
      logic [3:0] e_p;
      logic prev;
      int edges;
      do_reset();
      width_cfg = 8'd0;
      gap_cfg   = 8'd0;
      prev  = 1'b0;
      edges = 0;
      for (int c = 0; c <= 12; c++) begin
         pulse_in = (c == 5 || c == 6);
         e_d = (c == 6 || c == 8);
         e_b = (c >= 6 && c <= 9);
         e_p = (c == 7) ? 4'd1 : 4'd0;
         if (data_out === 1'b1 && prev === 1'b0) edges++;
         prev = data_out;
         n_cmp++;
         if (data_out !== e_d) begin n_err++; $display("FAIL zero_data c=%0d got=%b want=%b", c, data_out, e_d); end
         n_cmp++;
         if (busy !== e_b) begin n_err++; $display("FAIL zero_busy c=%0d got=%b want=%b", c, busy, e_b); end
         n_cmp++;
         if (pend_cnt !== e_p) begin n_err++; $display("FAIL zero_pend c=%0d got=%0d want=%0d", c, pend_cnt, e_p); end
         @(posedge clk); #1;
      end
      pulse_in = 1'b0;
      n_cmp++;
      if (edges != 2) begin n_err++; $display("FAIL zero_edges got=%0d want=2", edges); end
   endtask

   task automatic test_overflow();
      logic e_o;
      logic [3:0] e_p;
      logic prev;
      int edges;
      int c;
      do_reset();
      width_cfg = 8'd50;
      gap_cfg   = 8'd1;
      prev  = 1'b0;
      edges = 0;
      for (c = 0; c <= 40; c++) begin
         // Strobe at 20 coincides with clr_ovf while the queue is full.
         pulse_in = (c <= 16) || (c == 20);
         clr_ovf  = (c == 20 || c == 30);
         e_p = (c <= 1) ? 4'd0 : (c <= 16) ? 4'(c - 1) : 4'd15;
         e_o = (c >= 17 && c <= 30);
         if (data_out === 1'b1 && prev === 1'b0) edges++;
         prev = data_out;
         n_cmp++;
         if (pend_cnt !== e_p) begin n_err++; $display("FAIL ovf_pend c=%0d got=%0d want=%0d", c, pend_cnt, e_p); end
         n_cmp++;
         if (overflow !== e_o) begin n_err++; $display("FAIL ovf_flag c=%0d got=%b want=%b", c, overflow, e_o); end
         @(posedge clk); #1;
      end
      pulse_in = 1'b0;
      clr_ovf  = 1'b0;
      while (busy === 1'b1 && c < 2000) begin
         if (data_out === 1'b1 && prev === 1'b0) edges++;
         prev = data_out;
         @(posedge clk); #1;
         c++;
      end
      n_cmp++;
      if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_timeout busy got=%b want=0 after %0d cycles", busy, c); end
      n_cmp++;
      if (edges != 16) begin n_err++; $display("FAIL ovf_pulses got=%0d want=16", edges); end
      n_cmp++;
      if (pend_cnt !== 4'd0) begin n_err++; $display("FAIL ovf_final_pend got=%0d want=0", pend_cnt); end
      n_cmp++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_final_flag got=%b want=0", overflow); end
   endtask

   task automatic test_simul_deq_enq();
      logic e_d, e_b;
      logic [3:0] e_p;
      do_reset();
      width_cfg = 8'd2;
      gap_cfg   = 8'd3;
      for (int c = 0; c <= 18; c++) begin
         pulse_in = (c == 0 || c == 1 || c == 5);
         e_d = (c == 1 || c == 2 || c == 6 || c == 7 || c == 11 || c == 12);
         e_b = (c >= 1 && c <= 15);
         e_p = (c >= 2 && c <= 10) ? 4'd1 : 4'd0;
         n_cmp++;
         if (data_out !== e_d) begin n_err++; $display("FAIL simul_data c=%0d got=%b want=%b", c, data_out, e_d); end
         n_cmp++;
         if (busy !== e_b) begin n_err++; $display("FAIL simul_busy c=%0d got=%b want=%b", c, busy, e_b); end
         n_cmp++;
         if (pend_cnt !== e_p) begin n_err++; $display("FAIL simul_pend c=%0d got=%0d want=%0d", c, pend_cnt, e_p); end
         n_cmp++;
         if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf c=%0d got=%b want=0", c, overflow); end
         @(posedge clk); #1;
      end
      pulse_in = 1'b0;
   endtask

   task automatic test_reset_mid_pulse();
      logic e_d, e_b;
      logic [3:0] e_p;
      do_reset();
      width_cfg = 8'd10;
      gap_cfg   = 8'd1;
      for (int c = 0; c <= 25; c++) begin
         pulse_in = (c == 5 || c == 7 || c == 8 || c == 9 || c == 20);
         rst      = (c == 12);
         e_d = (c >= 6 && c <= 12) || (c >= 21);
         e_b = e_d;
         e_p = (c == 8) ? 4'd1 : (c == 9) ? 4'd2 : (c >= 10 && c <= 12) ? 4'd3 : 4'd0;
         n_cmp++;
         if (data_out !== e_d) begin n_err++; $display("FAIL rstmid_data c=%0d got=%b want=%b", c, data_out, e_d); end
         n_cmp++;
         if (busy !== e_b) begin n_err++; $display("FAIL rstmid_busy c=%0d got=%b want=%b", c, busy, e_b); end
         n_cmp++;
         if (pend_cnt !== e_p) begin n_err++; $display("FAIL rstmid_pend c=%0d got=%0d want=%0d", c, pend_cnt, e_p); end
         n_cmp++;
         if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf c=%0d got=%b want=0", c, overflow); end
         @(posedge clk); #1;
      end
      pulse_in = 1'b0;
      rst      = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      pulse_in  = 1'b0;
      clr_ovf   = 1'b0;
      width_cfg = 8'd1;
      gap_cfg   = 8'd1;
      test_reset();
      test_single();
      test_back_to_back();
      test_zero_cfg();
      test_overflow();
      test_simul_deq_enq();
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
